alpha_fade_controller: RTL and testbench



---
 rtl/alpha_fade_controller_pkg.sv | 36 +++
 rtl/alpha_fade_controller_blend_pipe.sv | 70 +++++++
 rtl/alpha_fade_controller.sv | 126 ++++++++++++
 tb/tb_alpha_fade_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alpha_fade_controller_pkg.sv
// Shared definitions for the alpha fade controller: command and state encodings,
// RGB888 channel layout and a channel extraction helper.
package blend_defs;

  localparam logic [1:0] CMD_FADE_IN  = 2'b01;
  localparam logic [1:0] CMD_FADE_OUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_FADE_OUT = 2'd2
  } state_t;

  localparam int PIX_W  = 24;
  localparam int CH_W   = 8;
  localparam int NUM_CH = 3;

  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  // Channel index 0 = blue, 1 = green, 2 = red, matching bit order in the word.
  function automatic logic [CH_W-1:0] ch_get(input logic [PIX_W-1:0] px, input int c);
    logic [CH_W-1:0] v;
    case (c)
      0:       v = px[B_HI:B_LO];
      1:       v = px[G_HI:G_LO];
      default: v = px[R_HI:R_LO];
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alpha_fade_controller_blend_pipe.sv
// Two-stage alpha blend datapath: stage 1 registers per-channel products,
// stage 2 registers the normalised sum or the non-overlapping OR pixel.
module blend_pipe
  import blend_defs::*;
#(
  parameter int ALPHA_N_LOG_2 = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ALPHA_N_LOG_2:0]   alpha_m,
  input  logic [PIX_W-1:0]         pixel_1,
  input  logic [PIX_W-1:0]         pixel_2,
  input  logic                     pixel_valid,
  output logic [PIX_W-1:0]         overlap_pixel,
  output logic                     out_valid
);

  localparam int AW = ALPHA_N_LOG_2 + 1;
  localparam int PW = CH_W + AW;
  localparam logic [AW-1:0] ALPHA_N = AW'(1 << ALPHA_N_LOG_2);

  logic [AW-1:0]                 w_alpha_inv;
  logic [NUM_CH-1:0][PW-1:0]     r_prod_1;
  logic [NUM_CH-1:0][PW-1:0]     r_prod_2;
  logic [NUM_CH-1:0][PW-1:0]     w_sum;
  logic [PIX_W-1:0]              w_blend;
  logic [PIX_W-1:0]              r_or_pix;
  logic                          r_overlap;
  logic                          r_valid_1;
  logic [PIX_W-1:0]              r_pix;
  logic                          r_valid_2;

  assign w_alpha_inv = ALPHA_N - alpha_m;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prod_1  <= '0;
      r_prod_2  <= '0;
      r_or_pix  <= '0;
      r_overlap <= 1'b0;
      r_valid_1 <= 1'b0;
      r_pix     <= '0;
      r_valid_2 <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_prod_1[c] <= PW'(ch_get(pixel_1, c)) * PW'(alpha_m);
        r_prod_2[c] <= PW'(ch_get(pixel_2, c)) * PW'(w_alpha_inv);
      end
      r_or_pix  <= pixel_1 | pixel_2;
      r_overlap <= |(pixel_1 & pixel_2);
      r_valid_1 <= pixel_valid;
      r_pix     <= r_overlap ? w_blend : r_or_pix;
      r_valid_2 <= r_valid_1;
    end
  end

  // Weights sum to N, so the shifted sum never exceeds a full channel.
  always_comb begin
    w_sum   = '0;
    w_blend = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sum[c] = r_prod_1[c] + r_prod_2[c];
      w_blend[c*CH_W +: CH_W] = CH_W'(w_sum[c] >> ALPHA_N_LOG_2);
    end
  end

  assign overlap_pixel = r_pix;
  assign out_valid     = r_valid_2;

endmodule

// File: rtl/alpha_fade_controller.sv
// Frame-synchronous fade sequencer owning the blend weight, driving the blend pipe.
// state       | meaning
// ST_IDLE     | weight static, commands accepted
// ST_FADE_IN  | weight steps toward N every FRAMES_PER_STEP frames
// ST_FADE_OUT | weight steps toward 0 every FRAMES_PER_STEP frames
module alpha_fade_controller
  import blend_defs::*;
#(
  parameter int ALPHA_N_LOG_2   = 4,
  parameter int ALPHA_INIT      = 8,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic [1:0]               cmd,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     abort,
  input  logic [PIX_W-1:0]         pixel_1,
  input  logic [PIX_W-1:0]         pixel_2,
  input  logic                     pixel_valid,
  output logic [PIX_W-1:0]         overlap_pixel,
  output logic                     out_valid,
  output logic [ALPHA_N_LOG_2:0]   alpha_m,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = ALPHA_N_LOG_2 + 1;
  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [AW-1:0] ALPHA_N    = AW'(1 << ALPHA_N_LOG_2);
  localparam logic [AW-1:0] ALPHA_ZERO = '0;
  localparam logic [CW-1:0] CNT_LAST   = CW'(FRAMES_PER_STEP - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_alpha;
  logic [AW-1:0]   w_alpha_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic [AW-1:0]   w_target;
  logic [AW-1:0]   w_alpha_step;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_alpha <= AW'(ALPHA_INIT);
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alpha <= w_alpha_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Abort outranks everything; a fade already at its endpoint finishes on the
  // next frame without touching the weight.
  always_comb begin
    w_state_nxt  = r_state;
    w_alpha_nxt  = r_alpha;
    w_cnt_nxt    = r_cnt;
    w_done_nxt   = 1'b0;
    w_target     = (r_state == ST_FADE_IN) ? ALPHA_N : ALPHA_ZERO;
    w_alpha_step = (r_state == ST_FADE_IN) ? r_alpha + 1'b1 : r_alpha - 1'b1;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && cmd == CMD_FADE_IN) begin
            w_state_nxt = ST_FADE_IN;
            w_cnt_nxt   = '0;
          end else if (cmd_valid && cmd == CMD_FADE_OUT) begin
            w_state_nxt = ST_FADE_OUT;
            w_cnt_nxt   = '0;
          end
        end
        ST_FADE_IN, ST_FADE_OUT: begin
          if (frame_start) begin
            if (r_alpha == w_target) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end else if (r_cnt == CNT_LAST) begin
              w_cnt_nxt   = '0;
              w_alpha_nxt = w_alpha_step;
              if (w_alpha_step == w_target) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
              end
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (r_state != ST_IDLE);
    cmd_ready = (r_state == ST_IDLE);
  end

  assign alpha_m = r_alpha;
  assign done    = r_done;

  blend_pipe #(
    .ALPHA_N_LOG_2 (ALPHA_N_LOG_2)
  ) u_blend_pipe (
    .clock         (clock),
    .reset         (reset),
    .alpha_m       (r_alpha),
    .pixel_1       (pixel_1),
    .pixel_2       (pixel_2),
    .pixel_valid   (pixel_valid),
    .overlap_pixel (overlap_pixel),
    .out_valid     (out_valid)
  );

endmodule

// File: tb/tb_alpha_fade_controller.sv
// Self-checking bench for alpha_fade_controller: fixed vectors, directed fade
// sequences and randomized traffic against an arithmetic reference model.
module tb_alpha_fade_controller;

  localparam int NN   = 16;
  localparam int INIT = 8;
  localparam int FPS  = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [1:0]  cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        abort;
  logic [23:0] pixel_1;
  logic [23:0] pixel_2;
  logic        pixel_valid;
  logic [23:0] overlap_pixel;
  logic        out_valid;
  logic [4:0]  alpha_m;
  logic        busy;
  logic        done;

  always #5 clock = ~clock;

  alpha_fade_controller #(
    .ALPHA_N_LOG_2   (4),
    .ALPHA_INIT      (INIT),
    .FRAMES_PER_STEP (FPS)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .frame_start   (frame_start),
    .cmd           (cmd),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .abort         (abort),
    .pixel_1       (pixel_1),
    .pixel_2       (pixel_2),
    .pixel_valid   (pixel_valid),
    .overlap_pixel (overlap_pixel),
    .out_valid     (out_valid),
    .alpha_m       (alpha_m),
    .busy          (busy),
    .done          (done)
  );

  typedef struct {
    int          alpha;
    logic [23:0] p1;
    logic [23:0] p2;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_alpha, m_busy, m_dir, m_frames, m_done;
  int m_s1_v, m_s1_px, m_out_v, m_out_px;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int blend_ref(input int p1, input int p2, input int m);
    int r;
    if ((p1 & p2) == 0) return p1 | p2;
    r = 0;
    for (int c = 0; c < 3; c++) begin
      int a, b;
      a = (p1 >> (8 * c)) & 255;
      b = (p2 >> (8 * c)) & 255;
      r |= ((a * m + b * (NN - m)) / NN) << (8 * c);
    end
    return r;
  endfunction

  task automatic check_all();
    check("alpha_m", alpha_m, m_alpha);
    check("busy", busy, m_busy);
    check("cmd_ready", cmd_ready, (m_busy == 0));
    check("done", done, m_done);
    check("out_valid", out_valid, m_out_v);
    if (m_out_v != 0) check("overlap_pixel", overlap_pixel, m_out_px);
  endtask

  task automatic step(input int fs, input int c, input int cv, input int ab,
                      input int p1, input int p2, input int pv);
    int a_pre, target;
    frame_start = fs[0];
    cmd         = c[1:0];
    cmd_valid   = cv[0];
    abort       = ab[0];
    pixel_1     = p1[23:0];
    pixel_2     = p2[23:0];
    pixel_valid = pv[0];
    a_pre  = m_alpha;
    m_done = 0;
    if (ab != 0) begin
      m_busy = 0;
    end else if (m_busy == 0) begin
      if (cv != 0 && (c == 1 || c == 2)) begin
        m_busy   = 1;
        m_dir    = (c == 1) ? 1 : -1;
        m_frames = 0;
      end
    end else if (fs != 0) begin
      target = (m_dir > 0) ? NN : 0;
      if (m_alpha == target) begin
        m_busy = 0;
        m_done = 1;
      end else begin
        m_frames++;
        if (m_frames % FPS == 0) begin
          m_alpha += m_dir;
          if (m_alpha == target) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
    end
    m_out_v  = m_s1_v;
    m_out_px = m_s1_px;
    m_s1_v   = pv;
    m_s1_px  = blend_ref(p1 & 24'hFFFFFF, p2 & 24'hFFFFFF, a_pre);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic rnd_step(input int fs, input int c, input int cv, input int ab);
    int p1, p2, pv;
    p1 = $urandom & 24'hFFFFFF;
    if ($urandom_range(0, 1) == 0) p2 = (~p1) & $urandom & 24'hFFFFFF;
    else                           p2 = $urandom & 24'hFFFFFF;
    pv = ($urandom_range(0, 3) != 0) ? 1 : 0;
    step(fs, c, cv, ab, p1, p2, pv);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      rnd_step(0, 0, 0, 0);
      rnd_step(0, 0, 0, 0);
      rnd_step(1, 0, 0, 0);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    frame_start = 1'b0;
    cmd_valid   = 1'b0;
    abort       = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    m_alpha  = INIT;
    m_busy   = 0;
    m_done   = 0;
    m_frames = 0;
    m_dir    = 1;
    m_s1_v   = 0;
    m_s1_px  = 0;
    m_out_v  = 0;
    m_out_px = 0;
    check_all();
    check("reset_overlap_pixel", overlap_pixel, 0);
    reset = 1'b0;
  endtask

  task automatic run_vec(input int a);
    foreach (tbl[i]) begin
      if (tbl[i].alpha == a) begin
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, int'(tbl[i].p1), int'(tbl[i].p2), 1);
        check("vec_latency_early", out_valid, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("vec_valid", out_valid, 1);
        check("vec_pixel", overlap_pixel, tbl[i].exp);
        step(0, 0, 0, 0, 0, 0, 0);
        check("vec_bubble", out_valid, 0);
      end
    end
  endtask

  initial begin
    tbl.push_back('{8,  24'hFF0000, 24'h00FF00, 24'hFFFF00});
    tbl.push_back('{8,  24'h808080, 24'h404040, 24'hC0C0C0});
    tbl.push_back('{8,  24'h808080, 24'hC0C0C0, 24'hA0A0A0});
    tbl.push_back('{8,  24'h000000, 24'h123456, 24'h123456});
    tbl.push_back('{8,  24'hFFFFFF, 24'h000001, 24'h7F7F80});
    tbl.push_back('{8,  24'h010000, 24'h010000, 24'h010000});
    tbl.push_back('{16, 24'h808080, 24'hC0C0C0, 24'h808080});
    tbl.push_back('{16, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF});
    tbl.push_back('{0,  24'h808080, 24'hC0C0C0, 24'hC0C0C0});
    tbl.push_back('{0,  24'h0000FF, 24'h00FF01, 24'h00FF01});

    reset = 1'b1;
    frame_start = 1'b0;
    cmd = 2'b00;
    cmd_valid = 1'b0;
    abort = 1'b0;
    pixel_1 = '0;
    pixel_2 = '0;
    pixel_valid = 1'b0;
    do_reset();

    run_vec(8);
    repeat (30) rnd_step(0, 0, 0, 0);

    // fade in with a fade-out strobe dropped mid-way
    rnd_step(0, 1, 1, 0);
    frames(3);
    rnd_step(0, 2, 1, 0);
    frames(13);
    rnd_step(0, 0, 0, 0);
    check("fade_in_end_alpha", alpha_m, 16);
    check("fade_in_end_ready", cmd_ready, 1);
    run_vec(16);

    // back down to 8, then an aborted fade-out
    rnd_step(0, 2, 1, 0);
    frames(16);
    check("fade_out_to_8", alpha_m, 8);
    rnd_step(0, 2, 1, 0);
    frames(5);
    rnd_step(0, 0, 0, 1);
    frames(2);
    check("abort_frozen_alpha", alpha_m, 6);
    rnd_step(0, 2, 1, 0);
    frames(12);
    rnd_step(0, 0, 0, 0);
    check("fade_out_to_0", alpha_m, 0);
    run_vec(0);

    // fade requested at its endpoint
    rnd_step(0, 2, 1, 0);
    check("endpoint_accepted", busy, 1);
    frames(1);
    check("endpoint_alpha", alpha_m, 0);

    // ignored commands in IDLE
    rnd_step(0, 3, 1, 0);
    check("cmd11_ignored", busy, 0);
    rnd_step(0, 1, 1, 1);
    check("abort_with_cmd", busy, 0);

    // abort coinciding with a stepping frame_start
    rnd_step(0, 1, 1, 0);
    frames(1);
    rnd_step(1, 0, 0, 1);
    check("abort_no_step", alpha_m, 0);

    // reset with a fade active and pixels in flight
    rnd_step(0, 1, 1, 0);
    frames(4);
    step(0, 0, 0, 0, 24'h111111, 24'h010101, 1);
    step(0, 0, 0, 0, 24'h222222, 24'h020202, 1);
    do_reset();
    check("reset_out_valid", out_valid, 0);
    check("reset_alpha", alpha_m, INIT);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rnd_step(($urandom_range(0, 3) == 0) ? 1 : 0,
               $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0) ? 1 : 0,
               ($urandom_range(0, 39) == 0) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
